rr_arbiter4: RTL and testbench
==============================

Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter with a bounded hold time, for sharing one resource between four masters.
- Successor to the three-way fixed-priority grant FSM. It adds rotating fairness, a maximum-tenure limit and a one-cycle turnaround gap between owners.
- Sits between the requesting masters and the shared resource's select mux; the grant vector drives the mux directly.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles per tenure while another requester is waiting. Legal range 2..255.
- CW, 8: hold counter width; must satisfy 2^CW > MAX_HOLD.

Ports:
- Clock  input  1  rising-edge clock
- Resetn  input  1  synchronous, active-low reset
- r  input  [3:0]  request vector; r[i] is held high by master i while it wants the resource
- g  output  [3:0]  registered one-hot grant, or all zero
- owner  output  [1:0]  index of the current or last grantee; valid when busy=1
- busy  output  1  high whenever any g bit is high
- lock  input  1  present only with ARB_LOCK_EN (see below)

Behaviour:
- Reset (Resetn=0 sampled at a Clock edge):
  - state=IDLE, g=0, busy=0, owner=0, hold counter=0.
  - Round-robin pointer ptr=0, so requester 0 is searched first.
  - Reset mid-tenure drops g on the same edge.
- States: IDLE, GRANT, GAP.
- Arbitration function:
  - Search r starting at index ptr and wrapping 3→0.
  - The first set bit wins.
  - Evaluated only in IDLE.
- IDLE:
  - r==0: stay in IDLE.
  - Otherwise, at the next edge: enter GRANT, set g[win]=1, owner=win, counter=1.
  - Latency from request to grant is 1 cycle.
- GRANT, evaluated each cycle on current inputs:
  - r[owner]==0: go to GAP at the next edge. g=0 and ptr=owner+1 (mod 4).
  - Else, if counter==MAX_HOLD and any other r bit is set (forced release): go to GAP; g=0, ptr=owner+1.
  - Else: stay in GRANT.
    - Counter increments and saturates at MAX_HOLD.
    - A sole requester therefore keeps the grant indefinitely.
- GAP:
  - Lasts exactly one cycle with g=0; the next edge always goes to IDLE.
  - busy=0 in GAP; owner holds the last grantee.
  - Consequence: there are 2 idle cycles between the end of one tenure and the start of the next.
  - This turnaround gap is mandatory, including when the next grantee is the same requester.
- Invariants:
  - g is one-hot or zero at all times.
  - g changes only on Clock edges.
  - busy == |g.
- Fairness:
  - With all four requesting continuously, grants rotate 0,1,2,3,0,...
  - Each tenure lasts MAX_HOLD cycles.
- Request dropped while not granted: no effect; requests are not latched.
- Simultaneous owner drop and hold expiry: treated as a normal release with identical timing.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds input port lock (1 bit, owner-driven).
  - While in GRANT with lock=1, forced release is suppressed; the counter still saturates.
  - Release occurs only when r[owner] drops.
  - lock is ignored in IDLE and GAP.
- Undefined:
  - Port lock does not exist.
  - Forced release always applies.

Test Plan:
1. Reset, then r=4'b0000 for 5 cycles → g=0, busy=0 throughout; then assert Resetn=0 mid-tenure → g=0 after that edge.
2. ptr=0, r=4'b0100 asserted at cycle t → g=4'b0100 and owner=2 from t+1; drop r at t+4 → g=0 from t+5, ptr=3.
3. r=4'b1111 held continuously, MAX_HOLD=8 → g sequence 0001×8, 0000×2, 0010×8, 0000×2, 0100×8, 0000×2, 1000×8, then back to 0001.
4. r=4'b0001 alone for 20 cycles → g=0001 for all 20 cycles. Then raise r[3] → release after the counter-saturated cycle, gap of 2, then g=1000.
5. r=4'b0011 simultaneously from IDLE with ptr=1 → g=0010 first, then 0001 next tenure after the gap.
6. ARB_LOCK_EN defined, owner 0 with lock=1 and r=4'b0011 for 30 cycles → g=0001 for all 30 cycles. lock=0 → release on the next edge, then g=0010 after the gap.

Source files
------------

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-requester round-robin arbiter with bounded hold and turnaround gap
// Optional owner lock input enabled by ARB_LOCK_EN.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8,
  parameter int CW       = 8
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [3:0] r,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] g,
  output logic [1:0] owner,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    g_nxt;
  logic [1:0]    owner_nxt;
  logic [1:0]    ptr, ptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    win, idx;
  logic          found;
  logic          others;
  logic          hold_max;
  logic          force_ok;

  // Rotating search: first set bit at or after ptr, wrapping 3 -> 0.
  always_comb begin
    win   = ptr;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  assign others   = |(r & ~(4'b0001 << owner));
  assign hold_max = (cnt == CW'(MAX_HOLD));

`ifdef ARB_LOCK_EN
  assign force_ok = ~lock;
`else
  assign force_ok = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    g_nxt     = g;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (|r) begin
          state_nxt = GRANT;
          g_nxt     = 4'b0001 << win;
          owner_nxt = win;
          cnt_nxt   = CW'(1);
        end
      end
      GRANT: begin
        if (!r[owner] || (hold_max && others && force_ok)) begin
          state_nxt = GAP;
          g_nxt     = 4'b0000;
          ptr_nxt   = owner + 2'd1;
        end else if (!hold_max) begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      GAP: begin
        state_nxt = IDLE;
        g_nxt     = 4'b0000;
      end
      default: begin
        state_nxt = IDLE;
        g_nxt     = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state <= IDLE;
      g     <= 4'b0000;
      owner <= 2'd0;
      ptr   <= 2'd0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      g     <= g_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign busy = |g;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - self-checking bench for rr_arbiter4
// Lock scenario runs only when ARB_LOCK_EN is defined.
module tb_rr_arbiter4;

  localparam int MAX_HOLD = 8;

  logic       Clock;
  logic       Resetn;
  logic [3:0] r;
  logic       lock_s;
  logic [3:0] g;
  logic [1:0] owner;
  logic       busy;

  int tests = 0;
  int fails = 0;

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD), .CW(8)) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .r     (r),
`ifdef ARB_LOCK_EN
    .lock  (lock_s),
`endif
    .g     (g),
    .owner (owner),
    .busy  (busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference model: tenure owner (-1 when none), tenure length, turnaround cycles left.
  int m_own  = -1;
  int m_last = 0;
  int m_ptr  = 0;
  int m_len  = 0;
  int m_cool = 0;

  task automatic model_step(input logic rst, input logic [3:0] rv, input logic lk);
    logic [3:0] mask;
    bit         fnd;
    int         c;
    if (rst) begin
      m_own = -1; m_last = 0; m_ptr = 0; m_len = 0; m_cool = 0;
    end else if (m_own >= 0) begin
      mask = 4'b0001 << m_own;
      if (!rv[m_own] || (m_len >= MAX_HOLD && (rv & ~mask) != 4'b0000 && !lk)) begin
        m_ptr  = (m_own + 1) % 4;
        m_own  = -1;
        m_cool = 1;
      end else begin
        m_len++;
      end
    end else if (m_cool > 0) begin
      m_cool--;
    end else if (rv != 4'b0000) begin
      fnd = 0;
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (!fnd && rv[c]) begin
          fnd = 1; m_own = c; m_last = c; m_len = 1;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic rst, input logic [3:0] rv, input logic lk);
    logic [3:0] mg;
    Resetn = ~rst;
    r      = rv;
    lock_s = lk;
    @(posedge Clock);
    model_step(rst, rv, lk);
    #1;
    mg = (m_own >= 0) ? (4'b0001 << m_own) : 4'b0000;
    chk("model_g", 32'(g), 32'(mg));
    chk("model_owner", 32'(owner), 32'(m_last));
    chk("busy_eq_or_g", 32'(busy), 32'(|mg));
    chk("g_onehot0", 32'($onehot0(g)), 32'd1);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] r;
    logic [3:0] eg;
    logic [1:0] eo;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rst, input logic [3:0] rv, input logic [3:0] eg, input logic [1:0] eo, input int n);
    vec_t v;
    v.rst = rst; v.r = rv; v.eg = eg; v.eo = eo;
    for (int i = 0; i < n; i++) vt.push_back(v);
  endtask

  initial begin
    logic [3:0] rr;
    logic       rs, lk;
    Resetn = 1'b0;
    r      = 4'b0000;
    lock_s = 1'b0;

    // Idle after reset, single request, then ptr=1 with two simultaneous requests, then mid-tenure reset.
    add(1, 4'b0000, 4'b0000, 2'd0, 1);
    add(0, 4'b0000, 4'b0000, 2'd0, 5);
    add(0, 4'b0100, 4'b0100, 2'd2, 4);
    add(0, 4'b0000, 4'b0000, 2'd2, 2);
    add(0, 4'b0001, 4'b0001, 2'd0, 1);
    add(0, 4'b0000, 4'b0000, 2'd0, 2);
    add(0, 4'b0011, 4'b0010, 2'd1, 8);
    add(0, 4'b0011, 4'b0000, 2'd1, 2);
    add(0, 4'b0011, 4'b0001, 2'd0, 3);
    add(1, 4'b0011, 4'b0000, 2'd0, 1);
    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].rst, vt[i].r, 1'b0);
      chk("vec_g", 32'(g), 32'(vt[i].eg));
      chk("vec_owner", 32'(owner), 32'(vt[i].eo));
      chk("vec_busy", 32'(busy), 32'(|vt[i].eg));
    end

    // All four requesting: 8-cycle tenures rotating 0,1,2,3,0 with 2-cycle gaps.
    cyc(1, 4'b0000, 1'b0);
    for (int n = 0; n < 42; n++) begin
      cyc(0, 4'b1111, 1'b0);
      chk("rotate_g", 32'(g), ((n % 10) < 8) ? (32'd1 << ((n / 10) % 4)) : 32'd0);
    end

    // Sole requester keeps the grant; a late competitor takes over after the gap.
    cyc(1, 4'b0000, 1'b0);
    for (int n = 0; n < 20; n++) begin
      cyc(0, 4'b0001, 1'b0);
      chk("sole_g", 32'(g), 32'h1);
    end
    cyc(0, 4'b1001, 1'b0);
    chk("handoff_gap1", 32'(g), 32'h0);
    cyc(0, 4'b1001, 1'b0);
    chk("handoff_gap2", 32'(g), 32'h0);
    cyc(0, 4'b1001, 1'b0);
    chk("handoff_g", 32'(g), 32'h8);
    chk("handoff_owner", 32'(owner), 32'd3);

`ifdef ARB_LOCK_EN
    cyc(1, 4'b0000, 1'b0);
    for (int n = 0; n < 30; n++) begin
      cyc(0, 4'b0011, 1'b1);
      chk("lock_g", 32'(g), 32'h1);
    end
    cyc(0, 4'b0011, 1'b0);
    chk("unlock_gap1", 32'(g), 32'h0);
    cyc(0, 4'b0011, 1'b0);
    chk("unlock_gap2", 32'(g), 32'h0);
    cyc(0, 4'b0011, 1'b0);
    chk("unlock_g", 32'(g), 32'h2);
`endif

    // Random request traffic with occasional resets against the model.
    cyc(1, 4'b0000, 1'b0);
    rr = 4'b0000;
    lk = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3, 0) == 0) rr = 4'($urandom_range(15, 0));
      rs = ($urandom_range(79, 0) == 0);
`ifdef ARB_LOCK_EN
      if ($urandom_range(7, 0) == 0) lk = ~lk;
`endif
      cyc(rs, rr, lk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
